sram_req_ctrl: RTL and testbench

Request front-end that sits directly upstream of the single-port SRAM and owns its `wr`/`addrs`/`din`/`dout` port. It turns a valid/ready command stream into SRAM cycles, returns read data through a buffered valid/ready response channel, and applies backpressure based on outstanding reads. After every reset it clears the whole array to a known value before accepting any traffic.

---
 rtl/sram_req_ctrl.sv | 124 ++++++++++++
 tb/tb_sram_req_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// Single-port SRAM front-end: clears the array after reset, then maps a valid/ready command
// stream onto SRAM cycles; read data returns 2 cycles after accept, with at most RSP_DEPTH reads outstanding.
module sram_req_ctrl #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter int                RSP_DEPTH = 4,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_wr,
  output logic [ADDR_W-1:0] sram_addrs,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              init_done
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(RSP_DEPTH);
  localparam logic [ADDR_W:0]   SWEEP_END = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W:0]   sweep_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [RSP_DEPTH];
  logic              rd_s1;
  logic              rd_s2;
  logic              req_acc;
  logic              rd_acc;
  logic              rsp_pop;

  assign req_ready = (state == RUN) && (out_cnt < DEPTH_C);
  assign req_acc   = req_valid && req_ready;
  assign rd_acc    = req_acc && !req_wr;
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;

  // The extra counter bit delays RUN by one cycle so the last sweep write is on the bus first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      init_done  <= 1'b0;
      sram_wr    <= 1'b0;
      sram_addrs <= '0;
      sram_din   <= '0;
    end else begin
      case (state)
        INIT: begin
          if (sweep_cnt == SWEEP_END) begin
            state     <= RUN;
            init_done <= 1'b1;
            sram_wr   <= 1'b0;
          end else begin
            sram_wr    <= 1'b1;
            sram_addrs <= sweep_cnt[ADDR_W-1:0];
            sram_din   <= INIT_VAL;
            sweep_cnt  <= sweep_cnt + (ADDR_W+1)'(1);
          end
        end
        RUN: begin
          sram_wr <= req_acc && req_wr;
          if (req_acc) begin
            sram_addrs <= req_addr;
            if (req_wr) sram_din <= req_wdata;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // rd_s1: address on the SRAM bus; rd_s2: sram_dout holds the data and is pushed this edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_s1   <= 1'b0;
      rd_s2   <= 1'b0;
      out_cnt <= '0;
    end else begin
      rd_s1 <= rd_acc;
      rd_s2 <= rd_s1;
      if (rd_acc && !rsp_pop)      out_cnt <= out_cnt + CNT_W'(1);
      else if (!rd_acc && rsp_pop) out_cnt <= out_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_s2) mem[wr_ptr] <= sram_dout;
  end

  // rsp_rdata is a registered copy of the FIFO head, refreshed on push-to-empty or pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      rsp_rdata <= '0;
    end else begin
      if (rd_s2)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (rsp_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (rd_s2 && !rsp_pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!rd_s2 && rsp_pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
      if (rd_s2 && ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && rsp_pop)))
        rsp_rdata <= sram_dout;
      else if (rsp_pop && (fifo_cnt > CNT_W'(1)))
        rsp_rdata <= mem[rd_ptr + PTR_W'(1)];
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Randomized bench for sram_req_ctrl: behavioural SRAM, golden memory and timestamped response queue.
module tb_sram_req_ctrl;
  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          sram_wr;
  logic [AW-1:0] sram_addrs;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic          init_done;

  logic [DW-1:0] sram [NWORDS];

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH), .INIT_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_wr(sram_wr), .sram_addrs(sram_addrs), .sram_din(sram_din),
    .sram_dout(sram_dout), .init_done(init_done)
  );

  // Single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_wr) sram[sram_addrs] <= sram_din;
    sram_dout <= sram[sram_addrs];
  end

  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
  typedef struct { logic [DW-1:0] data; int t; } rsp_t;

  cmd_t          cmds[$];
  rsp_t          pend[$];
  logic [DW-1:0] ref_mem [NWORDS];
  int            now;
  int            rel;
  int            n_tests;
  int            n_fail;
  int            rdy_pct;
  int            rst_hold;
  logic          exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, now);
    end
  endtask

  function automatic logic exp_rsp_vld();
    return (pend.size() > 0) && (pend[0].t + 2 <= now);
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = exp_rsp_vld();
    if (rel == 0) begin
      check_val("rst_req_ready", 32'(req_ready), 0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 0);
      check_val("rst_rsp_rdata", 32'(rsp_rdata), 0);
      check_val("rst_sram_wr", 32'(sram_wr), 0);
      check_val("rst_sram_addrs", 32'(sram_addrs), 0);
      check_val("rst_sram_din", 32'(sram_din), 0);
      check_val("rst_init_done", 32'(init_done), 0);
    end else if (rel <= NWORDS) begin
      check_val("sweep_wr", 32'(sram_wr), 1);
      check_val("sweep_addr", 32'(sram_addrs), 32'(rel - 1));
      check_val("sweep_din", 32'(sram_din), 0);
      check_val("sweep_init_done", 32'(init_done), 0);
      check_val("sweep_req_ready", 32'(req_ready), 0);
      check_val("sweep_rsp_valid", 32'(rsp_valid), 0);
    end else begin
      check_val("run_init_done", 32'(init_done), 1);
      check_val("run_req_ready", 32'(req_ready), 32'(pend.size() < DEPTH));
      check_val("run_sram_wr", 32'(sram_wr), 32'(exp_wr));
      check_val("run_sram_addrs", 32'(sram_addrs), 32'(exp_addr));
      if (exp_wr) check_val("run_sram_din", 32'(sram_din), 32'(exp_din));
      check_val("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) check_val("rsp_rdata", 32'(rsp_rdata), 32'(pend[0].data));
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, check at the next falling edge.
  task automatic step();
    logic acc;
    logic pop;
    cmd_t c;
    rsp_ready = ($urandom_range(99) < rdy_pct);
    if (cmds.size() > 0) begin
      req_valid = 1'b1;
      req_wr    = cmds[0].wr;
      req_addr  = cmds[0].addr;
      req_wdata = cmds[0].data;
    end else begin
      req_valid = 1'b0;
      req_wr    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
    end
    rst = (rst_hold == 0);
    if (rst_hold > 0) rst_hold--;
    acc = req_valid && (rel > NWORDS) && (pend.size() < DEPTH);
    pop = rsp_ready && exp_rsp_vld();
    @(posedge clk);
    now++;
    if (!rst) begin
      rel = 0;
      pend.delete();
      exp_wr = 1'b0;
      exp_addr = '0;
      exp_din = '0;
    end else begin
      rel++;
      exp_wr = 1'b0;
      if (rel == NWORDS + 1) begin
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
        exp_addr = AW'(NWORDS - 1);
        exp_din  = '0;
      end
      if (pop) void'(pend.pop_front());
      if (acc) begin
        c = cmds.pop_front();
        exp_addr = c.addr;
        if (c.wr) begin
          exp_wr = 1'b1;
          exp_din = c.data;
          ref_mem[c.addr] = c.data;
        end else begin
          pend.push_back('{data: ref_mem[c.addr], t: now});
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (cmds.size() > 0 || pend.size() > 0); i++) step();
    run(2);
  endtask

  task automatic push_cmd(input logic wr, input int addr, input int data);
    cmds.push_back('{wr: wr, addr: AW'(addr), data: DW'(data)});
  endtask

  initial begin
    n_tests = 0; n_fail = 0; now = 0; rel = 0;
    rdy_pct = 100; rst_hold = 1;
    exp_wr = 1'b0; exp_addr = '0; exp_din = '0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
    @(negedge clk);
    now = 1;
    check_outputs();

    // Reset, then the full clear sweep, then a read of a cleared word.
    run(NWORDS + 4);
    push_cmd(1'b0, 9, 0);
    drain();

    // Write then read-after-write on consecutive accepts.
    push_cmd(1'b1, 3, 8'hA5);
    push_cmd(1'b0, 3, 0);
    drain();

    // Credit exhaustion with the consumer stalled, then release.
    for (int a = 0; a < 6; a++) push_cmd(1'b1, a, 8'h10 + a);
    for (int a = 0; a < 6; a++) push_cmd(1'b0, a, 0);
    rdy_pct = 0;
    run(16);
    rdy_pct = 100;
    drain();

    // Full FIFO drained while new reads keep arriving.
    rdy_pct = 0;
    for (int a = 0; a < 8; a++) push_cmd(1'b0, $urandom_range(NWORDS - 1), 0);
    run(8);
    rdy_pct = 100;
    drain();

    // Reset in the middle of the sweep.
    rst_hold = 1;
    run(9);
    rst_hold = 1;
    run(NWORDS + 3);

    // Reset right after a read is accepted: the read must vanish.
    push_cmd(1'b0, 2, 0);
    for (int i = 0; i < 10 && pend.size() == 0; i++) step();
    rst_hold = 1;
    run(NWORDS + 4);

    // Random traffic with random backpressure and occasional resets.
    rdy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if (cmds.size() == 0 && $urandom_range(3) != 0)
        push_cmd(1'($urandom), $urandom_range(NWORDS - 1), $urandom_range(255));
      if ($urandom_range(799) == 0) rst_hold = 1 + $urandom_range(1);
      step();
    end
    rdy_pct = 100;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
